run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 121 ++++++++++++
 tb/tb_run_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Sequences NUM_PROGS CPU programs per go request, timing each one in RUN cycles
// and reporting per-program cycle counts with a timeout guard.
module run_controller #(
  parameter int NUM_PROGS = 3,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             cpu_done,
  output logic             cpu_start,
  output logic [1:0]       prog_sel,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic             result_valid,
  output logic             timed_out,
  output logic             all_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_CLR = 3'd2,
    RUN      = 3'd3,
    REPORT   = 3'd4,
    FINISH   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] COUNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] COUNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] COUNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] COUNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       PROG_LAST   = 2'(NUM_PROGS - 1);

  state_t           state;
  state_t           nextState;
  logic [1:0]       progNext;
  logic [CNT_W-1:0] countNext;
  logic             timedOutNext;

  // Next-state and next-datapath decode; done takes priority over timeout in RUN.
  always_comb begin
    nextState    = state;
    progNext     = prog_sel;
    countNext    = cycle_count;
    timedOutNext = timed_out;
    case (state)
      IDLE, FINISH: begin
        if (go) begin
          nextState    = START;
          progNext     = 2'd0;
          countNext    = COUNT_ZERO;
          timedOutNext = 1'b0;
        end else begin
          nextState = state;
        end
      end
      START: begin
        nextState = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!cpu_done) begin
          nextState = RUN;
        end else begin
          nextState = WAIT_CLR;
        end
      end
      RUN: begin
        if (cpu_done) begin
          nextState    = REPORT;
          timedOutNext = 1'b0;
        end else if (cycle_count >= COUNT_LAST) begin
          // saturate at the limit so the counter can never wrap
          nextState    = REPORT;
          countNext    = COUNT_LIMIT;
          timedOutNext = 1'b1;
        end else begin
          nextState = RUN;
          countNext = cycle_count + COUNT_ONE;
        end
      end
      REPORT: begin
        if (prog_sel == PROG_LAST) begin
          nextState = FINISH;
        end else begin
          nextState = START;
          progNext  = prog_sel + 2'd1;
          countNext = COUNT_ZERO;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State and output registers; status flags are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      prog_sel     <= 2'd0;
      cycle_count  <= COUNT_ZERO;
      timed_out    <= 1'b0;
      cpu_start    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      all_done     <= 1'b0;
    end else begin
      state        <= nextState;
      prog_sel     <= progNext;
      cycle_count  <= countNext;
      timed_out    <= timedOutNext;
      cpu_start    <= (nextState == START);
      busy         <= (nextState inside {START, WAIT_CLR, RUN, REPORT});
      result_valid <= (nextState == REPORT);
      all_done     <= (nextState == FINISH);
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller with TIMEOUT=50; the bench drives cpu_done
// as a simple CPU would and checks every report against hand-computed values.
module tb_run_controller;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             go;
  logic             cpu_done;
  logic             cpu_start;
  logic [1:0]       prog_sel;
  logic             busy;
  logic [CNT_W-1:0] cycle_count;
  logic             result_valid;
  logic             timed_out;
  logic             all_done;

  int nCompared = 0;
  int nFail     = 0;

  always #5 clk = ~clk;

  run_controller #(.NUM_PROGS(3), .CNT_W(CNT_W), .TIMEOUT(50)) dut (
    .clk(clk), .reset(reset), .go(go), .cpu_done(cpu_done),
    .cpu_start(cpu_start), .prog_sel(prog_sel), .busy(busy),
    .cycle_count(cycle_count), .result_valid(result_valid),
    .timed_out(timed_out), .all_done(all_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_cpu_start"}, 32'(cpu_start), 32'd0);
    check({tag, "_prog_sel"}, 32'(prog_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
    check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_timed_out"}, 32'(timed_out), 32'd0);
    check({tag, "_all_done"}, 32'(all_done), 32'd0);
  endtask

  task automatic checkFinish(input string tag, input int expCount, input int expTo);
    check({tag, "_all_done"}, 32'(all_done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_prog_sel"}, 32'(prog_sel), 32'd2);
    check({tag, "_cycle_count"}, 32'(cycle_count), expCount);
    check({tag, "_timed_out"}, 32'(timed_out), expTo);
  endtask

  // runCycles < 0 means the CPU never halts; stale > 0 keeps done high after start.
  task automatic runProg(input string tag, input int expProg, input int runCycles,
                         input int stale, input int expCount, input int expTo,
                         input bit goInRun, input bit goInReport);
    for (int i = 0; i < 30; i++) begin
      if (cpu_start === 1'b1) break;
      @(negedge clk);
    end
    check({tag, "_start"}, 32'(cpu_start), 32'd1);
    check({tag, "_start_prog"}, 32'(prog_sel), expProg);
    check({tag, "_start_count"}, 32'(cycle_count), 32'd0);
    if (stale > 0) begin
      cpu_done = 1'b1;
      repeat (stale) @(negedge clk);
      check({tag, "_wclr_busy"}, 32'(busy), 32'd1);
      check({tag, "_wclr_start"}, 32'(cpu_start), 32'd0);
      check({tag, "_wclr_count"}, 32'(cycle_count), 32'd0);
      cpu_done = 1'b0;
      @(negedge clk);
    end else begin
      cpu_done = 1'b0;
      repeat (2) @(negedge clk);
    end
    check({tag, "_run0_count"}, 32'(cycle_count), 32'd0);
    if (runCycles >= 0) begin
      for (int i = 0; i < runCycles; i++) begin
        go = (goInRun && i == 2);
        @(negedge clk);
      end
      go = 1'b0;
      cpu_done = 1'b1;
    end
    for (int i = 0; i < 80; i++) begin
      if (result_valid === 1'b1) break;
      @(negedge clk);
    end
    check({tag, "_valid"}, 32'(result_valid), 32'd1);
    check({tag, "_prog"}, 32'(prog_sel), expProg);
    check({tag, "_count"}, 32'(cycle_count), expCount);
    check({tag, "_timed_out"}, 32'(timed_out), expTo);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    go = goInReport;
    @(negedge clk);
    go = 1'b0;
    check({tag, "_valid_pulse"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    int sawValid;
    reset    = 1'b1;
    go       = 1'b0;
    cpu_done = 1'b1;
    #2;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);

    // first go is honoured on the first edge after release
    reset = 1'b0;
    go    = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("first_go_start", 32'(cpu_start), 32'd1);
    check("first_go_busy", 32'(busy), 32'd1);

    // nominal 10/20/30 with go pulses in RUN and REPORT
    runProg("nom0", 0, 10, 0, 10, 0, 1'b0, 1'b0);
    runProg("nom1", 1, 20, 0, 20, 0, 1'b1, 1'b1);
    runProg("nom2", 2, 30, 0, 30, 0, 1'b1, 1'b1);
    checkFinish("nom_fin", 30, 0);
    repeat (3) @(negedge clk);
    checkFinish("nom_hold", 30, 0);

    // stale done, simultaneous done/timeout, then a plain timeout
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    runProg("stale", 0, 5, 4, 5, 0, 1'b0, 1'b0);
    runProg("simul", 1, 49, 0, 49, 0, 1'b0, 1'b0);
    runProg("tmo", 2, -1, 0, 50, 1, 1'b0, 1'b0);
    checkFinish("mix_fin", 50, 1);

    // every program times out
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    runProg("tmo0", 0, -1, 0, 50, 1, 1'b0, 1'b0);
    runProg("tmo1", 1, -1, 0, 50, 1, 1'b0, 1'b0);
    runProg("tmo2", 2, -1, 0, 50, 1, 1'b0, 1'b0);
    checkFinish("tmo_fin", 50, 1);

    // reset asserted mid-RUN at cycle_count=7
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("rst_start", 32'(cpu_start), 32'd1);
    cpu_done = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_pre_count", 32'(cycle_count), 32'd7);
    #2 reset = 1'b1;
    #1;
    checkAllZero("rst_async");
    @(negedge clk);
    reset = 1'b0;
    sawValid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) sawValid = 1;
    end
    check("rst_no_valid", sawValid, 32'd0);
    check("rst_idle_busy", 32'(busy), 32'd0);
    check("rst_idle_all_done", 32'(all_done), 32'd0);
    check("rst_idle_start", 32'(cpu_start), 32'd0);

    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    runProg("post0", 0, 3, 0, 3, 0, 1'b0, 1'b0);
    runProg("post1", 1, 4, 0, 4, 0, 1'b0, 1'b0);
    runProg("post2", 2, 5, 0, 5, 0, 1'b0, 1'b0);
    checkFinish("post_fin", 5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
